// File: rtl/fetch_stage_bp_if.sv
// Fetch-stage bundle: execute-stage control/update inputs, instruction-memory port
// and the fetched pc/instruction/prediction outputs toward IF/ID.
interface fetch_stage_bp_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [DATA_W-1:0] instruction;
  logic              valid;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  modport master (
    output stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output imem_rdata,
    input  imem_addr, pc, pc_plus1, instruction, valid, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  imem_rdata,
    output imem_addr, pc, pc_plus1, instruction, valid, pred_taken, pred_target
  );
endinterface

// File: rtl/fetch_stage_bp.sv
// Instruction fetch stage: PC register, zero-bubble redirect, stall hold and a
// direct-mapped BTB with 2-bit saturating counters steering the next PC.
module fetch_stage_bp #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int RESET_PC    = 0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_bp_if.slave  bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_plus1;

  logic [BTB_ENTRIES-1:0] w_btb_valid;
  logic [TAG_W-1:0]       w_btb_tag    [BTB_ENTRIES];
  logic [ADDR_W-1:0]      w_btb_target [BTB_ENTRIES];
  logic [1:0]             w_btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;

  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;

  assign w_pc_plus1 = r_pc + ADDR_W'(1);

  assign w_idx         = r_pc[IDX_W-1:0];
  assign w_tag         = r_pc[ADDR_W-1:IDX_W];
  assign w_hit         = w_btb_valid[w_idx] && (w_btb_tag[w_idx] == w_tag);
  assign w_pred_taken  = w_hit && w_btb_ctr[w_idx][1];
  assign w_pred_target = w_pred_taken ? w_btb_target[w_idx] : '0;

  assign w_upd_idx = bus.upd_pc[IDX_W-1:0];
  assign w_upd_tag = bus.upd_pc[ADDR_W-1:IDX_W];
  assign w_upd_hit = w_btb_valid[w_upd_idx] && (w_btb_tag[w_upd_idx] == w_upd_tag);

  // Holding pc while valid is low makes the first post-reset cycle re-read RESET_PC.
  always_comb begin
    w_next_pc = w_pc_plus1;
    if (rst) begin
      w_next_pc = LP_RESET_PC;
    end else if (bus.redirect) begin
      w_next_pc = bus.redirect_pc;
    end else if (bus.stall || !r_valid) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= LP_RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_valid <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
      localparam logic [IDX_W-1:0] LP_IDX = IDX_W'(gi);
      logic              r_v;
      logic [TAG_W-1:0]  r_tag;
      logic [ADDR_W-1:0] r_target;
      logic [1:0]        r_ctr;
      logic              w_sel;

      assign w_sel = bus.upd_valid && (w_upd_idx == LP_IDX);

      // Lookups read these registers directly, so an update is only seen next cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v      <= 1'b0;
          r_tag    <= '0;
          r_target <= '0;
          r_ctr    <= 2'd1;
        end else if (w_sel) begin
          if (w_upd_hit) begin
            if (bus.upd_taken) begin
              r_target <= bus.upd_target;
              if (r_ctr != 2'd3) r_ctr <= r_ctr + 2'd1;
            end else if (r_ctr != 2'd0) begin
              r_ctr <= r_ctr - 2'd1;
            end
          end else if (bus.upd_taken) begin
            r_v      <= 1'b1;
            r_tag    <= w_upd_tag;
            r_target <= bus.upd_target;
            r_ctr    <= 2'd2;
          end
        end
      end

      assign w_btb_valid[gi]  = r_v;
      assign w_btb_tag[gi]    = r_tag;
      assign w_btb_target[gi] = r_target;
      assign w_btb_ctr[gi]    = r_ctr;
    end
  endgenerate

  assign bus.imem_addr   = w_next_pc;
  assign bus.pc          = r_pc;
  assign bus.pc_plus1    = w_pc_plus1;
  assign bus.instruction = bus.imem_rdata;
  assign bus.valid       = r_valid;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;
endmodule

// File: tb/tb_fetch_stage_bp.sv
// Scoreboard bench for fetch_stage_bp: directed scenarios then random traffic,
// expectations from a PC/BTB reference model, checked by an independent monitor.
module tb_fetch_stage_bp;
  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 32;
  localparam int BTB_ENTRIES = 16;
  localparam int RESET_PC    = 0;
  localparam int DEPTH       = 1 << ADDR_W;

  logic clk = 1'b1;
  logic rst;

  fetch_stage_bp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_stage_bp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BTB_ENTRIES(BTB_ENTRIES), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  typedef struct {
    int pc;
    int pc_plus1;
    bit valid;
    logic [DATA_W-1:0] instr;
    bit pt;
    int ptgt;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each BTB slot remembers the full pc that owns it.
  int m_pc;
  bit m_valid;
  bit m_v     [BTB_ENTRIES];
  int m_owner [BTB_ENTRIES];
  int m_tgt   [BTB_ENTRIES];
  int m_ctr   [BTB_ENTRIES];

  function automatic void model_predict(input int p, output bit pt, output int tgt);
    int idx;
    idx = p % BTB_ENTRIES;
    pt  = m_v[idx] && (m_owner[idx] == p) && (m_ctr[idx] >= 2);
    tgt = pt ? m_tgt[idx] : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit rd, input int rpc,
                       input bit uv, input int upc, input bit ut, input int utgt);
    bit   pt;
    int   tgt;
    int   npc;
    int   idx;
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.stall       = s;
    bus.redirect    = rd;
    bus.redirect_pc = ADDR_W'(rpc);
    bus.upd_valid   = uv;
    bus.upd_pc      = ADDR_W'(upc);
    bus.upd_taken   = ut;
    bus.upd_target  = ADDR_W'(utgt);

    model_predict(m_pc, pt, tgt);
    if (r)                    npc = RESET_PC;
    else if (rd)              npc = rpc;
    else if (s || !m_valid)   npc = m_pc;
    else if (pt)              npc = tgt;
    else                      npc = (m_pc + 1) % DEPTH;

    if (r) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        m_v[i] = 1'b0; m_ctr[i] = 1; m_tgt[i] = 0; m_owner[i] = 0;
      end
    end else if (uv) begin
      idx = upc % BTB_ENTRIES;
      if (m_v[idx] && m_owner[idx] == upc) begin
        if (ut) begin
          m_tgt[idx] = utgt;
          if (m_ctr[idx] < 3) m_ctr[idx]++;
        end else if (m_ctr[idx] > 0) begin
          m_ctr[idx]--;
        end
      end else if (ut) begin
        m_v[idx] = 1'b1; m_owner[idx] = upc; m_tgt[idx] = utgt; m_ctr[idx] = 2;
      end
    end

    m_pc    = npc;
    m_valid = !r;
    e.pc       = m_pc;
    e.pc_plus1 = (m_pc + 1) % DEPTH;
    e.valid    = m_valid;
    e.instr    = mem[m_pc];
    model_predict(m_pc, e.pt, e.ptgt);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int upc, input bit ut, input int utgt);
    cycle(0, 0, 0, 0, 1, upc, ut, utgt);
  endtask

  task automatic jump(input int rpc);
    cycle(0, 0, 1, rpc, 0, 0, 0, 0);
  endtask

  // Monitor: the state after each rising edge is matched to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("valid", 32'(bus.valid), 32'(e.valid));
        check("pc", 32'(bus.pc), e.pc);
        check("pc_plus1", 32'(bus.pc_plus1), e.pc_plus1);
        check("pred_taken", 32'(bus.pred_taken), 32'(e.pt));
        check("pred_target", 32'(bus.pred_target), e.ptgt);
        if (e.valid) check("instruction", bus.instruction, e.instr);
      end
    end
  end

  initial begin
    bit r, s, rd, uv, ut;
    int rpc, upc, utgt;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom_range(0, 65535), 16'(i)};
    m_pc = 0;
    m_valid = 1'b0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;

    repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    upd(8, 1, 40);
    jump(5);
    idle(6);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 20, 0, 0, 0, 0);
    idle(2);
    repeat (3) upd(8, 0, 0);
    jump(7);
    idle(3);
    upd(8, 1, 40);
    upd(8, 1, 40);
    jump(7);
    idle(3);
    jump(24);
    idle(2);
    jump(8);
    upd(8, 0, 0);
    jump(8);
    idle(2);
    jump(DEPTH - 2);
    idle(4);

    for (int k = 0; k < 1500; k++) begin
      r    = ($urandom_range(0, 99) == 0);
      s    = ($urandom_range(0, 4) == 0);
      rd   = ($urandom_range(0, 9) == 0);
      rpc  = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1)
                                         : $urandom_range(0, 63);
      uv   = ($urandom_range(0, 2) == 0);
      upc  = $urandom_range(0, 63);
      ut   = ($urandom_range(0, 9) < 6);
      utgt = $urandom_range(0, 63);
      cycle(r, s, rd, rpc, uv, upc, ut, utgt);
    end
    idle(2);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage_bp.md
Name: fetch_stage_bp

Overview:
Parametrised next-generation instruction fetch stage for the pipelined core. It keeps the PC and drives a synchronous-read instruction memory with a zero-bubble redirect path. It adds stall hold, a reset-valid qualifier and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters that predicts next PC. Sits ahead of the IF/ID register; redirect and predictor update come from the execute stage.

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width
DATA_W, 32, instruction width
BTB_ENTRIES, 16, BTB depth; power of two, >=2; IDX_W = log2(BTB_ENTRIES), must be < ADDR_W
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold the fetch stage
redirect  in  1  execute-stage correction (mispredict, jump, jr)
redirect_pc  in  ADDR_W  corrected next PC
upd_valid  in  1  resolved control-flow instruction report
upd_pc  in  ADDR_W  PC of resolved instruction
upd_taken  in  1  resolved outcome
upd_target  in  ADDR_W  resolved taken target
imem_addr  out  ADDR_W  address to synchronous IM (data returns next cycle)
imem_rdata  in  DATA_W  IM read data
pc  out  ADDR_W  PC of current instruction
pc_plus1  out  ADDR_W  pc+1, modulo 2^ADDR_W
instruction  out  DATA_W  = imem_rdata
valid  out  1  pc/instruction pair meaningful
pred_taken  out  1  BTB prediction for pc
pred_target  out  ADDR_W  BTB target for pc (0 when pred_taken=0)

Behaviour:
- imem_addr = next_pc (combinational); pc <= next_pc each edge; instruction at pc appears one cycle after its address is issued.
- next_pc priority: rst -> RESET_PC; redirect -> redirect_pc; stall -> pc; valid==0 -> pc; pred_taken -> pred_target; else pc_plus1.
- valid: reset 0; set 1 on every edge with rst=0. First post-reset cycle re-reads RESET_PC, so mem[RESET_PC] is presented with valid=1 in the 2nd cycle after rst falls.
- Reset mid-operation: pc=RESET_PC, valid=0 next cycle, BTB cleared regardless of stall/redirect/upd_valid.
- Stall: pc, valid unchanged; IM re-reads pc so instruction stable. Redirect overrides stall (redirect_pc fetched, stall ignored that edge).
- Redirect: zero bubbles; instruction at redirect_pc presented the following cycle with valid=1.
- Wrap: pc+1 from 2^ADDR_W-1 gives 0.
- BTB entry: valid bit, tag = addr[ADDR_W-1:IDX_W], target ADDR_W, ctr 2 bits. Index = addr[IDX_W-1:0].
- Lookup (combinational on pc): hit = valid & tag match; pred_taken = hit & ctr>=2; pred_target = target when pred_taken else 0.
- Update on upd_valid edge: hit -> ctr saturating +1 if taken (max 3), -1 if not (min 0); target <= upd_target if taken. Miss & taken -> allocate/overwrite: valid=1, tag, target, ctr=2. Miss & not taken -> no change.
- Updates occur during stall and redirect. No bypass: a lookup of the same index in the update cycle sees old contents; new contents visible next cycle.
- Reset: all entries valid=0, ctr=1, target=0.

Test Plan:
- Reset: rst 3 cycles, release, IM word[i]=i -> cycle+1 valid=0 pc=0; cycle+2 valid=1 pc=0 instruction=0; then pc 1,2,3 one per cycle.
- Wrap: ADDR_W=4 build, free-run -> pc 14,15,0,1; pc_plus1 at 15 is 0.
- Stall/redirect: stall high 3 cycles at pc=5 -> pc=5 and instruction constant; assert redirect_pc=20 during stall -> next cycle pc=20, instruction=word[20], no bubble.
- BTB allocate/predict: upd_valid pc=8 taken target=40 -> when pc later reaches 8: pred_taken=1, pred_target=40, next pc=40.
- Saturation: three not-taken updates at pc=8 -> ctr 2->1->0->0, pred_taken=0, fetch 8->9; two taken updates -> ctr 0->1->2, pred_taken=1 again.
- Alias/same-cycle: BTB_ENTRIES=16, entry at pc=8 -> pc=24 misses (tag mismatch, pred_taken=0); update at idx 8 in cycle pc=8 -> that cycle old prediction, next lookup new.
